ring_counter_4b: RTL and testbench



---
 rtl/ring_counter_4b.sv | 64 ++++++
 tb/tb_ring_counter_4b.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ring_counter_4b.sv
// One-hot ring counter with position index, terminal flag and self-correction.
// An illegal (non-one-hot) ring reloads the start pattern and pulses err.
module ring_counter_4b #(
  parameter int WIDTH = 4,
  parameter int DIR   = 0,
  parameter int POS_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q,
  output logic [POS_W-1:0] pos,
  output logic             term,
  output logic             err
);

  localparam logic [WIDTH-1:0] START    = (DIR == 0) ? {1'b1, {(WIDTH-1){1'b0}}}
                                                     : {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("ring_counter_4b: WIDTH must be in 2..32");
  end
  if (POS_W != (($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH))) begin : g_bad_pos_w
    $error("ring_counter_4b: POS_W must equal ceil(log2(WIDTH))");
  end

  logic             legal;
  logic [WIDTH-1:0] q_next;
  logic [POS_W-1:0] pos_next;
  logic             err_next;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign legal = (q != '0) && ((q & (q - WIDTH'(1))) == '0);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    q_next   = START;
    pos_next = '0;
    err_next = 1'b0;
    if (!legal) begin
      err_next = 1'b1;
    end else begin
      if (DIR == 0) q_next = {q[0], q[WIDTH-1:1]};
      else          q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      pos_next = (pos == LAST_POS) ? '0 : pos + POS_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all bits update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= START;
      pos <= '0;
      err <= 1'b0;
    end else begin
      q   <= q_next;
      pos <= pos_next;
      err <= err_next;
    end
  end

  assign term = (pos == LAST_POS);

endmodule

// File: tb/tb_ring_counter_4b.sv
// Directed bench for ring_counter_4b: default right ring, a left ring and an
// 8-bit ring sharing one clock and reset.
module tb_ring_counter_4b;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] q_d, q_l;
  logic [1:0] pos_d, pos_l;
  logic       term_d, term_l, err_d, err_l;
  logic [7:0] q_w;
  logic [2:0] pos_w;
  logic       term_w, err_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ring_counter_4b dut_d (
    .clk(clk), .reset(reset), .q(q_d), .pos(pos_d), .term(term_d), .err(err_d)
  );
  ring_counter_4b #(.WIDTH(4), .DIR(1), .POS_W(2)) dut_l (
    .clk(clk), .reset(reset), .q(q_l), .pos(pos_l), .term(term_l), .err(err_l)
  );
  ring_counter_4b #(.WIDTH(8), .DIR(0), .POS_W(3)) dut_w (
    .clk(clk), .reset(reset), .q(q_w), .pos(pos_w), .term(term_w), .err(err_w)
  );

  typedef struct {
    logic       rst;
    logic [3:0] exp_q;
    logic [1:0] exp_pos;
    logic       exp_term;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Set reset away from the edge, clock once, then sample just after the edge.
  task automatic step(input logic rst);
    @(negedge clk);
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check_d(input string tag, input logic [3:0] eq, input logic [1:0] ep,
                         input logic et, input logic ee);
    check({tag, ".q"},    32'(q_d),    32'(eq));
    check({tag, ".pos"},  32'(pos_d),  32'(ep));
    check({tag, ".term"}, 32'(term_d), 32'(et));
    check({tag, ".err"},  32'(err_d),  32'(ee));
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 4'b1000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0100, 2'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0010, 2'd2, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0001, 2'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'b1000, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'b0100, 2'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0010, 2'd2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'b1000, 2'd0, 1'b0, 1'b0};  // reset while at 0010
    vecs[8]  = '{1'b1, 4'b1000, 2'd0, 1'b0, 1'b0};  // held in reset
    vecs[9]  = '{1'b0, 4'b0100, 2'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b0010, 2'd2, 1'b0, 1'b0};

    // Reset state of all three rings.
    step(1'b1);
    check_d("rst_d", 4'b1000, 2'd0, 1'b0, 1'b0);
    check("rst_l.q", 32'(q_l), 32'h1);
    check("rst_l.term", 32'(term_l), 32'h0);
    check("rst_w.q", 32'(q_w), 32'h80);
    check("rst_w.err", 32'(err_w), 32'h0);

    // Table-driven default ring, including mid-sequence reset.
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rst);
      check_d($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_pos,
              vecs[i].exp_term, vecs[i].exp_err);
    end

    // Left ring and 8-bit ring from a fresh reset, one ring period of the wide one.
    step(1'b1);
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] eq_l;
      logic [7:0] eq_w;
      step(1'b0);
      eq_l = 4'b0001 << (k % 4);
      eq_w = 8'h80 >> (k % 8);
      check($sformatf("left%0d.q", k), 32'(q_l), 32'(eq_l));
      check($sformatf("left%0d.pos", k), 32'(pos_l), 32'(k % 4));
      check($sformatf("left%0d.term", k), 32'(term_l), 32'((k % 4) == 3));
      check($sformatf("w8_%0d.q", k), 32'(q_w), 32'(eq_w));
      check($sformatf("w8_%0d.pos", k), 32'(pos_w), 32'(k % 8));
      check($sformatf("w8_%0d.term", k), 32'(term_w), 32'((k % 8) == 7));
    end

    // Long free run of the default ring.
    step(1'b1);
    for (int k = 1; k <= 100; k++) begin
      logic [3:0] eq;
      step(1'b0);
      eq = 4'b1000 >> (k % 4);
      check($sformatf("run%0d.q", k), 32'(q_d), 32'(eq));
      check($sformatf("run%0d.term", k), 32'(term_d), 32'((k % 4) == 3));
    end

    // Illegal states: plant a bad value between edges, then expect correction.
    step(1'b1);
    step(1'b0);
    check_d("pre_bad", 4'b0100, 2'd1, 1'b0, 1'b0);
    @(negedge clk);
    force dut_d.q = 4'b0110;
    #1 release dut_d.q;
    @(posedge clk);
    #1;
    check_d("fix0110", 4'b1000, 2'd0, 1'b0, 1'b1);
    step(1'b0);
    check_d("after0110", 4'b0100, 2'd1, 1'b0, 1'b0);
    step(1'b0);
    check_d("resume0110", 4'b0010, 2'd2, 1'b0, 1'b0);
    @(negedge clk);
    force dut_d.q = 4'b0000;
    #1 release dut_d.q;
    @(posedge clk);
    #1;
    check_d("fix0000", 4'b1000, 2'd0, 1'b0, 1'b1);
    step(1'b0);
    check_d("after0000", 4'b0100, 2'd1, 1'b0, 1'b0);
    check("left_no_err", 32'(err_l), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
